// File: rtl/motor_pwm_ctrl.sv
// motor_pwm_ctrl: multi-channel H-bridge PWM with dead-time coast; OC_PROT_EN adds overcurrent fault latching
module motor_pwm_ctrl #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 19,
  parameter int PERIOD   = 250000,
  parameter int DEAD_CYC = 50000,
  parameter int OC_LIMIT = 249999
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*CNT_W-1:0] duty,
  input  logic [NUM_CH-1:0]       dir,
  input  logic [NUM_CH-1:0]       sense,
  input  logic [NUM_CH-1:0]       fault_clr,
  output logic [NUM_CH-1:0]       pwm,
  output logic [NUM_CH-1:0]       in_a,
  output logic [NUM_CH-1:0]       in_b,
  output logic [NUM_CH-1:0]       fault,
  output logic [NUM_CH-1:0]       dead,
  output logic                    tick
);
  localparam int DW = $clog2(DEAD_CYC + 1);
  localparam logic [1:0] RUN = 2'd0, DEAD = 2'd1, FAULT = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic wrap;
  always_comb begin
    wrap  = cnt_q == LAST;
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
  end
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign tick = wrap;
`ifndef OC_PROT_EN
  logic unused_in;
  assign unused_in = ^{sense, fault_clr, OC_LIMIT[0]};
`endif
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [DW-1:0] dead_cnt_q, dead_cnt_d;
    logic [1:0] state_q, state_d;
    logic dir_q, dir_d, pwm_q, pwm_d, in_a_q, in_a_d, in_b_q, in_b_d;
    logic trip, clr;
`ifdef OC_PROT_EN
    localparam int OW = $clog2(OC_LIMIT + 1);
    logic [OW-1:0] oc_cnt_q, oc_cnt_d;
    always_comb begin
      trip     = oc_cnt_q == OW'(OC_LIMIT);
      clr      = fault_clr[g] && !sense[g];
      oc_cnt_d = !sense[g] ? '0 : trip ? oc_cnt_q : oc_cnt_q + OW'(1);
    end
    always_ff @(posedge clk)
      if (rst) oc_cnt_q <= '0;
      else     oc_cnt_q <= oc_cnt_d;
    assign fault[g] = state_q == FAULT;
`else
    assign trip     = 1'b0;
    assign clr      = 1'b0;
    assign fault[g] = 1'b0;
`endif
    // outputs are registered from the next state so pins and dead flag change on the same edge
    always_comb begin
      duty_d     = wrap ? duty[g*CNT_W +: CNT_W] : duty_q;
      dead_cnt_d = dead_cnt_q;
      dir_d      = dir_q;
      state_d    = state_q;
      if (trip)
        state_d = FAULT;
      else if (state_q == RUN && dir[g] != dir_q) begin
        state_d    = DEAD;
        dead_cnt_d = DW'(DEAD_CYC);
      end else if (state_q == DEAD) begin
        dead_cnt_d = dead_cnt_q - DW'(1);
        if (dead_cnt_d == '0) begin
          state_d = RUN;
          dir_d   = dir[g];
        end
      end else if (state_q == FAULT && clr) begin
        state_d    = DEAD;
        dead_cnt_d = DW'(DEAD_CYC);
      end
      pwm_d  = state_d == RUN && cnt_q < duty_q;
      in_a_d = state_d == RUN && dir_d;
      in_b_d = state_d == RUN && !dir_d;
    end
    always_ff @(posedge clk)
      if (rst) begin
        duty_q     <= '0;
        dead_cnt_q <= '0;
        state_q    <= RUN;
        dir_q      <= 1'b1;
        pwm_q      <= 1'b0;
        in_a_q     <= 1'b1;
        in_b_q     <= 1'b0;
      end else begin
        duty_q     <= duty_d;
        dead_cnt_q <= dead_cnt_d;
        state_q    <= state_d;
        dir_q      <= dir_d;
        pwm_q      <= pwm_d;
        in_a_q     <= in_a_d;
        in_b_q     <= in_b_d;
      end
    assign pwm[g]  = pwm_q;
    assign in_a[g] = in_a_q;
    assign in_b[g] = in_b_q;
    assign dead[g] = state_q == DEAD;
  end
endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// tb_motor_pwm_ctrl: scoreboard bench comparing every cycle against a timestamp-based reference model
module tb_motor_pwm_ctrl;
  localparam int NUM_CH = 2, CNT_W = 8, PERIOD = 100, DEAD_CYC = 10, OC_LIMIT = 20;
  localparam int EW = 5 * NUM_CH + 1;
  localparam int M_RUN = 0, M_DEAD = 1, M_FAULT = 2;
`ifdef OC_PROT_EN
  localparam bit OC = 1'b1;
`else
  localparam bit OC = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [NUM_CH*CNT_W-1:0] duty = '0;
  logic [NUM_CH-1:0] dir = '1, sense = '0, fault_clr = '0;
  logic [NUM_CH-1:0] pwm, in_a, in_b, fault, dead;
  logic tick;
  always #5 clk = ~clk;
  motor_pwm_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .DEAD_CYC(DEAD_CYC), .OC_LIMIT(OC_LIMIT)) dut (
    .clk(clk), .rst(rst), .duty(duty), .dir(dir), .sense(sense), .fault_clr(fault_clr),
    .pwm(pwm), .in_a(in_a), .in_b(in_b), .fault(fault), .dead(dead), .tick(tick)
  );
  typedef struct packed {
    logic [EW-1:0] exp;
    logic [31:0]   ph;
    logic [31:0]   cyc;
  } item_t;
  item_t sb[$];
  int checks = 0, errors = 0;
  int cyc = 0;
  int mduty[NUM_CH], mode[NUM_CH], dead_end[NUM_CH], hi_run[NUM_CH];
  bit mdir[NUM_CH];
  // one call per clock: evaluate the model for the inputs now applied, queue the result, advance a cycle
  task automatic step(input int ph);
    logic [NUM_CH-1:0] e_pwm, e_a, e_b, e_f, e_d;
    logic e_t;
    item_t it;
    int c;
    c = cyc % PERIOD;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (rst) begin
        mduty[ch] = 0; mdir[ch] = 1'b1; mode[ch] = M_RUN; hi_run[ch] = 0;
        e_pwm[ch] = 1'b0;
      end else begin
        if (OC && hi_run[ch] >= OC_LIMIT) mode[ch] = M_FAULT;
        else if (mode[ch] == M_RUN && dir[ch] != mdir[ch]) begin
          mode[ch] = M_DEAD; dead_end[ch] = cyc + DEAD_CYC;
        end else if (mode[ch] == M_DEAD && cyc == dead_end[ch]) begin
          mode[ch] = M_RUN; mdir[ch] = dir[ch];
        end else if (mode[ch] == M_FAULT && fault_clr[ch] && !sense[ch]) begin
          mode[ch] = M_DEAD; dead_end[ch] = cyc + DEAD_CYC;
        end
        hi_run[ch] = !sense[ch] ? 0 : (hi_run[ch] + 1 > OC_LIMIT ? OC_LIMIT : hi_run[ch] + 1);
        e_pwm[ch] = mode[ch] == M_RUN && c < mduty[ch];
        if (c == PERIOD - 1) mduty[ch] = int'(duty[ch*CNT_W +: CNT_W]);
      end
      e_a[ch] = mode[ch] == M_RUN && mdir[ch];
      e_b[ch] = mode[ch] == M_RUN && !mdir[ch];
      e_f[ch] = mode[ch] == M_FAULT;
      e_d[ch] = mode[ch] == M_DEAD;
    end
    cyc = rst ? 0 : cyc + 1;
    e_t = !rst && (cyc % PERIOD) == PERIOD - 1;
    it.exp = {e_t, e_pwm, e_a, e_b, e_f, e_d};
    it.ph  = ph;
    it.cyc = cyc;
    sb.push_back(it);
    @(negedge clk);
  endtask
  initial begin : monitor
    item_t it;
    logic [EW-1:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        it  = sb.pop_front();
        got = {tick, pwm, in_a, in_b, fault, dead};
        checks++;
        if (got !== it.exp) begin
          errors++;
          $display("FAIL ph%0d cyc%0d {tick,pwm,in_a,in_b,fault,dead} got=%b exp=%b", it.ph, it.cyc, got, it.exp);
        end
      end
    end
  end
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end
  initial begin : stim
    @(negedge clk);
    repeat (3) step(0);
    rst = 1'b0;
    duty = {8'd60, 8'd25};
    repeat (250) step(1);
    while (cyc % PERIOD != 40) step(2);
    duty[7:0] = 8'd75;
    repeat (210) step(2);
    duty[7:0] = 8'd0;   repeat (200) step(3);
    duty[7:0] = 8'd100; repeat (200) step(4);
    duty[7:0] = 8'd255; repeat (200) step(5);
    duty[7:0] = 8'd50;  repeat (120) step(6);
    dir[0] = 1'b0; repeat (4) step(7);
    dir[0] = 1'b1; repeat (2) step(7);
    dir[0] = 1'b0; repeat (150) step(7);
    dir[1] = 1'b0; repeat (60) step(8);
    dir[0] = 1'b1; repeat (4) step(9);
    rst = 1'b1; step(9);
    rst = 1'b0; dir = '1; repeat (40) step(9);
    sense = '1; repeat (1000) step(10);
    sense = '0; repeat (3) step(10);
    fault_clr = '1; step(10);
    fault_clr = '0; repeat (30) step(10);
    sense[0] = 1'b1; repeat (19) step(11);
    sense[0] = 1'b0; repeat (5) step(11);
    sense[0] = 1'b1; repeat (25) step(12);
    fault_clr[0] = 1'b1; repeat (3) step(12);
    fault_clr[0] = 1'b0; sense[0] = 1'b0; repeat (3) step(12);
    fault_clr[0] = 1'b1; step(12);
    fault_clr[0] = 1'b0; repeat (30) step(12);
    sense[0] = 1'b1; repeat (25) step(13);
    rst = 1'b1; step(13);
    rst = 1'b0; sense = '0; duty = {8'd30, 8'd70}; repeat (40) step(13);
    for (int k = 0; k < 3000; k++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if ($urandom_range(0, 199) == 0) dir[ch] = ~dir[ch];
        if ($urandom_range(0, 49) == 0) duty[ch*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 130));
        sense[ch] = $urandom_range(0, 9) < (k % 600 < 60 ? 9 : 1);
        fault_clr[ch] = $urandom_range(0, 29) == 0;
      end
      rst = $urandom_range(0, 999) == 0;
      step(14);
    end
    rst = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never compared, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/motor_pwm_ctrl.md
MOTOR_PWM_CTRL -- requirements
Module: motor_pwm_ctrl

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent motor channels.
REQ-002 Parameter CNT_W, default 19: width of the period counter and the duty commands.
REQ-003 Parameter PERIOD, default 250000: carrier period in clk cycles (400 Hz at 100 MHz); SHALL be in the range 2..2^CNT_W-1.
REQ-004 Parameter DEAD_CYC, default 50000: coast cycles inserted on a direction change or a fault exit; SHALL be at least 1.
REQ-005 Parameter OC_LIMIT, default 249999: consecutive high current-sense cycles that trip a fault.
REQ-006 clk  input  1  system clock, 100 MHz; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 duty  input  NUM_CH*CNT_W  per-channel on-time in cycles; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-009 dir  input  NUM_CH  per-channel direction command; 1 = forward, 0 = reverse.
REQ-010 sense  input  NUM_CH  per-channel overcurrent comparator; active high; already synchronised.
REQ-011 fault_clr  input  NUM_CH  per-channel fault-clear request, level-sampled.
REQ-012 pwm  output  NUM_CH  registered per-channel bridge enable (PWM).
REQ-013 in_a, in_b  output  NUM_CH each  registered per-channel bridge direction pins.
REQ-014 fault  output  NUM_CH  latched overcurrent flag.
REQ-015 dead  output  NUM_CH  high while a channel is in DEAD.
REQ-016 tick  output  1  one-cycle pulse when cnt == PERIOD-1.

Function
REQ-017 A single shared counter cnt SHALL count 0..PERIOD-1 and then wrap to 0.
REQ-018 duty_q[i] SHALL load duty[i] only on the cycle cnt == PERIOD-1, so a new duty takes effect from cnt = 0 and mid-period changes never glitch the output.
REQ-019 A duty_q value of 0 SHALL give a constant low pwm; a duty_q value >= PERIOD SHALL give a constant high pwm (100%).
REQ-020 Each channel SHALL implement states RUN, DEAD and FAULT (FAULT only when the macro is set).
REQ-021 In RUN, pwm[i] at edge n+1 SHALL equal (cnt < duty_q[i]) evaluated at edge n, i.e. one cycle of latency.
REQ-022 In RUN, in_a = dir_q and in_b = ~dir_q.
REQ-023 In RUN, dir[i] != dir_q[i] SHALL cause entry to DEAD and load dead_cnt = DEAD_CYC.
REQ-024 In DEAD, pwm = 0 and in_a = in_b = 0 (coast); dead_cnt decrements every cycle.
REQ-025 When dead_cnt reaches 0, the channel SHALL set dir_q <= dir[i] (its value on that cycle) and return to RUN.
REQ-026 dir toggling during DEAD SHALL neither restart nor shorten the dead time.
REQ-027 in_a and in_b SHALL never both be 1.
REQ-028 The direction pins SHALL never switch polarity without an intervening DEAD of at least DEAD_CYC cycles.
REQ-029 Channels SHALL be fully independent; only cnt and tick are shared.

Reset
REQ-030 rst SHALL force the following on the next edge: cnt = 0, tick = 0, duty_q = 0, dir_q = 1, state = RUN, pwm = 0, in_a = 1, in_b = 0, fault = 0, dead = 0, oc_cnt = 0, dead_cnt = 0.
REQ-031 rst asserted mid-DEAD or mid-FAULT SHALL abort the operation with no residual state; rst overrides all other inputs.

Configuration
REQ-032 Macro OC_PROT_EN defined: each channel keeps an oc_cnt that increments while sense[i] = 1, saturating at OC_LIMIT, and clears to 0 when sense[i] = 0.
REQ-033 With OC_PROT_EN, oc_cnt reaching OC_LIMIT SHALL move the channel from any state to FAULT on the next edge; FAULT has priority over a simultaneous direction change.
REQ-034 In FAULT, fault = 1, pwm = 0 and in_a = in_b = 0.
REQ-035 In FAULT, fault_clr[i] = 1 while sense[i] = 0 SHALL clear fault and enter DEAD with dead_cnt = DEAD_CYC; fault_clr while sense[i] = 1 SHALL be ignored.
REQ-036 Macro OC_PROT_EN undefined: sense and fault_clr are ignored, fault is tied to 0, and no FAULT state or oc_cnt logic is synthesised.

Verification (NUM_CH=2, PERIOD=100, DEAD_CYC=10, OC_LIMIT=20)
REQ-037 Reset, then duty0 = 25 and dir0 = 1 -> from the first full period, pwm0 is high 25 of every 100 cycles, in_a0 = 1 and in_b0 = 0; tick pulses every 100 cycles.
REQ-038 duty0 changed from 25 to 75 at cnt = 40 -> the current period keeps 25 high cycles; the next period has 75; duty 0 gives constant low; duty 100 or 255 gives constant high.
REQ-039 dir0 1->0 in RUN -> pwm0 = in_a0 = in_b0 = 0 and dead0 = 1 for 10 cycles, then in_a0 = 0 and in_b0 = 1 and PWM resumes; channel 1 is unaffected throughout.
REQ-040 OC_PROT_EN set, sense0 high for 19 cycles then low -> no fault; sense0 high for 20 cycles -> fault0 = 1 and pwm0 = 0; fault_clr0 with sense0 high -> no effect; fault_clr0 with sense0 low -> 10-cycle DEAD, then RUN.
REQ-041 rst pulsed mid-DEAD and mid-FAULT -> every output matches its REQ-030 value on the next edge; with OC_PROT_EN undefined, sense held high for 1000 cycles -> fault stays 0.
